jtframe_dump_window: RTL and testbench
======================================

// Module: jtframe_dump_window
// PURPOSE
//  Frame-window scheduler for waveform/logic-analyser capture in game test benches and on-chip debug.
//  - Counts video frames on falling edges of the vertical sync.
//  - Holds off while a ROM download is in progress.
//  - Asserts dump_en for a programmed window of frames.
//  - Sits between the video timing / download status and the capture sink: the dump control block
//    in simulation, or a SignalTap trigger on hardware.
// PARAMETERS
//  CW      32  width of frame counter, start_frame and win_len
//  VS_POL  0   0: frame boundary = falling edge of vs; 1: rising edge
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  vs           in   1   vertical sync, synchronous to clk
//  downloading  in   1   1 while ROM download in progress
//  start_frame  in   CW  frame number at which the window opens
//  win_len      in   CW  window length in frames; 0 = never close
//  frame_cnt    out  CW  frames since download end
//  dump_en      out  1   high while window is open
//  dump_start   out  1   one-cycle pulse when window opens
//  dump_stop    out  1   one-cycle pulse when window closes
//  busy         out  1   high in WAIT_START or ACTIVE
// BEHAVIOUR
//  - Reset: all outputs 0, state=WAIT_DL, vs edge-detect register cleared to 0 (inactive level for VS_POL=0).
//  - Frame tick (fr):
//    - Edge of vs per VS_POL, detected against a one-cycle delayed copy.
//    - fr is high in the cycle after the edge: one cycle of latency.
//  - WAIT_DL:
//    - Exit on the first fr with downloading=0.
//    - On exit: frame_cnt<=0; latch st<=start_frame, ln<=win_len.
//    - Next state is ACTIVE if start_frame==0 (dump_start pulses), else WAIT_START.
//  - WAIT_START:
//    - On fr: frame_cnt<=frame_cnt+1.
//    - When the new value equals st: go ACTIVE, dump_start=1 for one cycle, wcnt<=0.
//  - ACTIVE:
//    - dump_en=1 (registered; rises in the same cycle as the dump_start pulse).
//    - On fr: frame_cnt++, wcnt++.
//    - If ln!=0 and the new wcnt==ln: dump_en<=0, dump_stop=1 for one cycle, go DONE.
//  - DONE: dump_en=0, frame_cnt keeps counting on fr, no further pulses.
//  - frame_cnt wraps modulo 2^CW; wcnt is CW bits and also wraps. A wcnt wrap never closes the window unless ln is matched.
//  - Inputs start_frame/win_len are only sampled on exit from WAIT_DL (or on re-arm); later changes are ignored.
//  - downloading=1 in any state:
//    - Go to WAIT_DL next cycle; dump_en<=0.
//    - If leaving ACTIVE, dump_stop pulses once.
//    - frame_cnt holds until the next exit from WAIT_DL clears it.
//  - Simultaneous fr and downloading=1: downloading wins; no count, no dump_start.
//  - Asynchronous reset mid-window: dump_en drops immediately with reset, no dump_stop pulse.
//  - dump_start and dump_stop are never high in the same cycle.
// CONFIGURATION
//  - JTFRAME_DUMP_REARM_EN defined:
//    - DONE is transient: the cycle after dump_stop, go WAIT_START and re-latch st<=frame_cnt+start_frame, ln<=win_len.
//    - The window repeats with gap start_frame frames.
//    - start_frame==0 in re-arm means the next window opens on the next fr.
//  - JTFRAME_DUMP_REARM_EN not defined: DONE is terminal until reset or a new download.
// TESTING
//  - Reset, downloading=0, start=3, len=2, vs period 100 clk -> frame_cnt=0 after 1st fr;
//    dump_start on 3rd fr after exit; dump_en for 2 frames; dump_stop with frame_cnt=5.
//  - start=0, len=0 -> dump_start on the exit fr; dump_en stays 1 for 50 frames; no dump_stop.
//  - Window open (start=1, len=10), downloading=1 at frame 4 ->
//    dump_en 0 next cycle, one dump_stop, state WAIT_DL, frame_cnt holds 4.
//    Release -> frame_cnt=0 on next fr, new window.
//  - CW=4, start=14, len=5 -> frame_cnt wraps 15->0; dump_stop when frame_cnt=3.
//  - Assert rst_n=0 while dump_en=1 -> all outputs 0 asynchronously, no pulses; after release the bench waits for a fr to leave WAIT_DL.
//  - With JTFRAME_DUMP_REARM_EN, start=2, len=1 -> dump_start at frames 2, 5, 8; dump_stop at 3, 6, 9.
//    Without the macro -> single window only.

Source files
------------

// File: rtl/jtframe_dump_window.sv
// jtframe_dump_window: frame-window scheduler for capture; JTFRAME_DUMP_REARM_EN makes the window repeat
module jtframe_dump_window #(
   parameter int CW     = 32,
   parameter bit VS_POL = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vs,
   input  logic          downloading,
   input  logic [CW-1:0] start_frame,
   input  logic [CW-1:0] win_len,
   output logic [CW-1:0] frame_cnt,
   output logic          dump_en,
   output logic          dump_start,
   output logic          dump_stop,
   output logic          busy
);
   typedef enum logic [1:0] {WAIT_DL, WAIT_START, ACTIVE, DONE} state_t;
   state_t        state;
   logic          vs_d, fr, vs_edge;
   logic [CW-1:0] st, ln, wcnt, fc_nx, wc_nx;
   assign vs_edge = VS_POL ? (vs & ~vs_d) : (~vs & vs_d);
   assign fc_nx   = frame_cnt + CW'(1);
   assign wc_nx   = wcnt + CW'(1);
   assign busy    = state == WAIT_START || state == ACTIVE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= WAIT_DL;
         vs_d       <= 1'b0;
         fr         <= 1'b0;
         frame_cnt  <= '0;
         st         <= '0;
         ln         <= '0;
         wcnt       <= '0;
         dump_en    <= 1'b0;
         dump_start <= 1'b0;
         dump_stop  <= 1'b0;
      end else begin
         vs_d       <= vs;
         fr         <= vs_edge;
         dump_start <= 1'b0;
         dump_stop  <= 1'b0;
         if (downloading) begin
            // frame_cnt holds until the next download exit clears it
            dump_stop <= state == ACTIVE;
            dump_en   <= 1'b0;
            state     <= WAIT_DL;
         end else begin
            case (state)
               WAIT_DL: if (fr) begin
                  frame_cnt <= '0;
                  st        <= start_frame;
                  ln        <= win_len;
                  wcnt      <= '0;
                  if (start_frame == '0) begin
                     state      <= ACTIVE;
                     dump_start <= 1'b1;
                     dump_en    <= 1'b1;
                  end else state <= WAIT_START;
               end
               WAIT_START: if (fr) begin
                  frame_cnt <= fc_nx;
                  if (fc_nx == st) begin
                     state      <= ACTIVE;
                     dump_start <= 1'b1;
                     dump_en    <= 1'b1;
                     wcnt       <= '0;
                  end
               end
               ACTIVE: if (fr) begin
                  frame_cnt <= fc_nx;
                  wcnt      <= wc_nx;
                  if (ln != '0 && wc_nx == ln) begin
                     state     <= DONE;
                     dump_en   <= 1'b0;
                     dump_stop <= 1'b1;
                  end
               end
               default: begin
                  if (fr) frame_cnt <= fc_nx;
`ifdef JTFRAME_DUMP_REARM_EN
                  // a zero gap still needs one more frame before reopening
                  state <= WAIT_START;
                  st    <= (fr ? fc_nx : frame_cnt) + (start_frame == '0 ? CW'(1) : start_frame);
                  ln    <= win_len;
`endif
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_jtframe_dump_window.sv
// tb_jtframe_dump_window: directed checks of frame counting, windowing, download abort, wrap and reset
module tb_jtframe_dump_window;
   logic        clk = 0, rst_n = 0, vs = 0, downloading = 0;
   logic [31:0] start_frame = 0, win_len = 0, frame_cnt;
   logic        dump_en, dump_start, dump_stop, busy;
   logic [3:0]  start4 = 0, len4 = 0, frame_cnt4;
   logic        dump_en4, dump_start4, dump_stop4, busy4;
   int          checks = 0, errors = 0;
   int          n_start = 0, n_stop = 0, n_both = 0, b_start, b_stop;

   jtframe_dump_window #(.CW(32)) dut (
      .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
      .start_frame(start_frame), .win_len(win_len), .frame_cnt(frame_cnt),
      .dump_en(dump_en), .dump_start(dump_start), .dump_stop(dump_stop), .busy(busy));

   jtframe_dump_window #(.CW(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
      .start_frame(start4), .win_len(len4), .frame_cnt(frame_cnt4),
      .dump_en(dump_en4), .dump_start(dump_start4), .dump_stop(dump_stop4), .busy(busy4));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dump_start) n_start <= n_start + 1;
      if (dump_stop) n_stop <= n_stop + 1;
      if (dump_start && dump_stop) n_both <= n_both + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one vs period of 100 clk; returns just after the resulting frame tick was processed
   task automatic frame();
      @(negedge clk) vs = 1;
      repeat (49) @(negedge clk);
      vs = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; vs = 0; downloading = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      b_start = n_start; b_stop = n_stop;
   endtask

   initial begin
      // reset state
      do_reset();
      rst_n = 0;
      #1;
      chk("rst frame_cnt", frame_cnt, 0);
      chk("rst dump_en", dump_en, 0);
      chk("rst dump_start", dump_start, 0);
      chk("rst dump_stop", dump_stop, 0);
      chk("rst busy", busy, 0);

      // start=3 len=2
      start_frame = 3; win_len = 2;
      do_reset();
      frame();
      chk("t1 exit cnt", frame_cnt, 0);
      chk("t1 exit busy", busy, 1);
      chk("t1 exit en", dump_en, 0);
      frame(); frame();
      chk("t1 f2 cnt", frame_cnt, 2);
      chk("t1 f2 en", dump_en, 0);
      frame();
      chk("t1 open cnt", frame_cnt, 3);
      chk("t1 open start", dump_start, 1);
      chk("t1 open en", dump_en, 1);
      @(posedge clk); #1;
      chk("t1 start pulse width", dump_start, 0);
      frame();
      chk("t1 f4 en", dump_en, 1);
      chk("t1 f4 stop", dump_stop, 0);
      frame();
      chk("t1 close cnt", frame_cnt, 5);
      chk("t1 close stop", dump_stop, 1);
      chk("t1 close en", dump_en, 0);
      @(posedge clk); #1;
      chk("t1 stop pulse width", dump_stop, 0);
`ifndef JTFRAME_DUMP_REARM_EN
      frame(); frame(); frame(); frame();
      chk("t1 single start", n_start - b_start, 1);
      chk("t1 single stop", n_stop - b_stop, 1);
      chk("t1 done busy", busy, 0);
      chk("t1 done cnt", frame_cnt, 9);
`endif

      // start=0 len=0: never closes
      start_frame = 0; win_len = 0;
      do_reset();
      frame();
      chk("t2 exit start", dump_start, 1);
      chk("t2 exit en", dump_en, 1);
      chk("t2 exit cnt", frame_cnt, 0);
      for (int i = 1; i <= 50; i++) begin
         frame();
         chk("t2 en held", dump_en, 1);
      end
      chk("t2 cnt", frame_cnt, 50);
      chk("t2 no stop", n_stop - b_stop, 0);

      // download aborts an open window
      start_frame = 1; win_len = 10;
      do_reset();
      frame();
      frame();
      chk("t3 open", dump_start, 1);
      frame(); frame(); frame();
      chk("t3 cnt4", frame_cnt, 4);
      @(negedge clk) downloading = 1;
      @(posedge clk); #1;
      chk("t3 dl en", dump_en, 0);
      chk("t3 dl stop", dump_stop, 1);
      chk("t3 dl busy", busy, 0);
      chk("t3 dl cnt", frame_cnt, 4);
      frame(); frame();
      chk("t3 hold cnt", frame_cnt, 4);
      chk("t3 one stop", n_stop - b_stop, 1);
      chk("t3 dl no start", n_start - b_start, 1);
      @(negedge clk) downloading = 0;
      frame();
      chk("t3 rel cnt", frame_cnt, 0);
      chk("t3 rel busy", busy, 1);
      frame();
      chk("t3 new window", dump_start, 1);
      chk("t3 new en", dump_en, 1);

      // CW=4 wrap
      start4 = 14; len4 = 5;
      do_reset();
      frame();
      chk("t4 exit cnt", 32'(frame_cnt4), 0);
      repeat (14) frame();
      chk("t4 open cnt", 32'(frame_cnt4), 14);
      chk("t4 open start", 32'(dump_start4), 1);
      frame(); frame();
      chk("t4 wrap cnt", 32'(frame_cnt4), 0);
      chk("t4 wrap en", 32'(dump_en4), 1);
      frame(); frame();
      chk("t4 pre stop", 32'(dump_stop4), 0);
      frame();
      chk("t4 close cnt", 32'(frame_cnt4), 3);
      chk("t4 close stop", 32'(dump_stop4), 1);
      chk("t4 close en", 32'(dump_en4), 0);

      // asynchronous reset mid-window
      start_frame = 0; win_len = 0;
      do_reset();
      frame();
      chk("t5 en", dump_en, 1);
      @(posedge clk); #3;
      b_stop = n_stop;
      rst_n = 0;
      #1;
      chk("t5 async en", dump_en, 0);
      chk("t5 async busy", busy, 0);
      chk("t5 async cnt", frame_cnt, 0);
      @(negedge clk); @(negedge clk);
      chk("t5 no stop", n_stop - b_stop, 0);
      rst_n = 1;
      b_start = n_start;
      repeat (3) @(negedge clk);
      chk("t5 idle", busy, 0);
      frame();
      chk("t5 reopen", dump_start, 1);
      chk("t5 reopen cnt", frame_cnt, 0);

      // rearm behaviour
      start_frame = 2; win_len = 1;
      do_reset();
      frame(); frame(); frame();
      chk("t6 open cnt", frame_cnt, 2);
      chk("t6 open start", dump_start, 1);
      frame();
      chk("t6 close stop", dump_stop, 1);
      repeat (6) frame();
      chk("t6 cnt", frame_cnt, 9);
`ifdef JTFRAME_DUMP_REARM_EN
      chk("t6 starts", n_start - b_start, 3);
      chk("t6 stops", n_stop - b_stop, 3);
      chk("t6 last stop", dump_stop, 1);
`else
      chk("t6 starts", n_start - b_start, 1);
      chk("t6 stops", n_stop - b_stop, 1);
      chk("t6 en", dump_en, 0);
`endif
      chk("never both pulses", n_both, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
